// File: rtl/cmul_pkg.sv
// Shared definitions for the round-robin complex-multiplier arbiter.
//   - default operand/result/tag widths
//   - operand and result records as packed structs
//   - rr_next_grant(): round-robin search used by the arbiter
package cmul_pkg;

    localparam int DW_DEF   = 16;
    localparam int OW_DEF   = 17;
    localparam int IDW_DEF  = 2;
    localparam int NREQ_MAX = 8;
    localparam int PTRW     = 3;   // wide enough to index NREQ_MAX requesters

    typedef struct packed {
        logic signed [DW_DEF-1:0] in1;
        logic signed [DW_DEF-1:0] in2;
        logic signed [DW_DEF-1:0] wr;
        logic signed [DW_DEF-1:0] wi;
    } cmul_op_t;

    typedef struct packed {
        logic        [IDW_DEF-1:0] id;
        logic signed [OW_DEF-1:0]  re;
        logic signed [OW_DEF-1:0]  im;
    } cmul_res_t;

    // Returns {found, index}. The search starts one past 'last' and wraps
    // modulo nreq. The loop runs from the farthest candidate towards the
    // nearest, so the nearest valid requester is the one that ends up in
    // 'pick'.
    function automatic logic [PTRW:0] rr_next_grant(
        input logic [NREQ_MAX-1:0] valid,
        input logic [PTRW-1:0]     last,
        input int                  nreq
    );
        logic [PTRW:0]   pick;
        logic [PTRW-1:0] idx;
        int              pos;
        pick = {(PTRW+1){1'b0}};
        for (int k = NREQ_MAX; k >= 1; k--) begin
            if (k <= nreq) begin
                pos = (int'(last) + k) % nreq;
                idx = pos[PTRW-1:0];
                if (valid[idx]) begin
                    pick = {1'b1, idx};
                end else begin
                    pick = pick;
                end
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Three-stage stallable signed complex multiplier with tag passthrough.
//   S0: operands and tag registered
//   S1: four signed products (2*DW bits each)
//   S2: re = rr - ii, im = ri + ir at 2*DW+1 bits, arithmetic shift by
//       SHIFT, low OW bits kept (wraps, no saturation)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            advance enable; low freezes every stage
//   in_valid/id   incoming operand set valid and requester tag
//   in1,in2,wr,wi incoming operands (two's complement)
//   out_*         S2 contents (registered result)
//   busy          any stage holds valid data
module cmul_pipe import cmul_pkg::*; #(
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = 0,
    parameter int IDW   = IDW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    input  logic [IDW-1:0] in_id,
    input  logic [DW-1:0]  in1,
    input  logic [DW-1:0]  in2,
    input  logic [DW-1:0]  wr,
    input  logic [DW-1:0]  wi,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [OW-1:0]  out_re,
    output logic [OW-1:0]  out_im,
    output logic           busy
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    logic                 s0_valid_r;
    logic [IDW-1:0]       s0_id_r;
    logic signed [DW-1:0] s0_in1_r, s0_in2_r, s0_wr_r, s0_wi_r;

    logic                 s1_valid_r;
    logic [IDW-1:0]       s1_id_r;
    logic signed [PW-1:0] s1_rr_r, s1_ii_r, s1_ri_r, s1_ir_r;

    logic                 s2_valid_r;
    logic [IDW-1:0]       s2_id_r;
    logic [OW-1:0]        s2_re_r, s2_im_r;

    logic signed [PW-1:0] prod_rr_s, prod_ii_s, prod_ri_s, prod_ir_s;
    logic signed [SW-1:0] sum_re_s, sum_im_s;
    logic [OW-1:0]        res_re_s, res_im_s;

    // Signed products: operands sign-extended to 2*DW first; the exact
    // product of two DW-bit values always fits, including -2^(DW-1) squared.
    always_comb begin
        prod_rr_s = PW'(s0_in1_r) * PW'(s0_wr_r);
        prod_ii_s = PW'(s0_in2_r) * PW'(s0_wi_r);
        prod_ri_s = PW'(s0_in1_r) * PW'(s0_wi_r);
        prod_ir_s = PW'(s0_in2_r) * PW'(s0_wr_r);
    end

    // Exact sum/difference at 2*DW+1 bits, then shift and truncate.
    always_comb begin
        sum_re_s = SW'(s1_rr_r) - SW'(s1_ii_r);
        sum_im_s = SW'(s1_ri_r) + SW'(s1_ir_r);
        res_re_s = OW'(sum_re_s >>> SHIFT);
        res_im_s = OW'(sum_im_s >>> SHIFT);
    end

    // Stage 0: capture operands and tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s0_id_r    <= {IDW{1'b0}};
            s0_in1_r   <= {DW{1'b0}};
            s0_in2_r   <= {DW{1'b0}};
            s0_wr_r    <= {DW{1'b0}};
            s0_wi_r    <= {DW{1'b0}};
        end else if (en) begin
            s0_valid_r <= in_valid;
            s0_id_r    <= in_id;
            s0_in1_r   <= in1;
            s0_in2_r   <= in2;
            s0_wr_r    <= wr;
            s0_wi_r    <= wi;
        end
    end

    // Stage 1: capture the four partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= {IDW{1'b0}};
            s1_rr_r    <= {PW{1'b0}};
            s1_ii_r    <= {PW{1'b0}};
            s1_ri_r    <= {PW{1'b0}};
            s1_ir_r    <= {PW{1'b0}};
        end else if (en) begin
            s1_valid_r <= s0_valid_r;
            s1_id_r    <= s0_id_r;
            s1_rr_r    <= prod_rr_s;
            s1_ii_r    <= prod_ii_s;
            s1_ri_r    <= prod_ri_s;
            s1_ir_r    <= prod_ir_s;
        end
    end

    // Stage 2: capture the final result; these registers drive the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_id_r    <= {IDW{1'b0}};
            s2_re_r    <= {OW{1'b0}};
            s2_im_r    <= {OW{1'b0}};
        end else if (en) begin
            s2_valid_r <= s1_valid_r;
            s2_id_r    <= s1_id_r;
            s2_re_r    <= res_re_s;
            s2_im_r    <= res_im_s;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_id    = s2_id_r;
    assign out_re    = s2_re_r;
    assign out_im    = s2_im_r;
    assign busy      = s0_valid_r | s1_valid_r | s2_valid_r;

endmodule

// File: rtl/cmul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined signed complex multiplier
// between NREQ requesters; each result is tagged with its requester index.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is one-hot or zero
//   req_in1/in2       data real/imag, requester i at [i*DW +: DW]
//   req_wr/wi         twiddle real/imag, same packing
//   res_valid/ready   result handshake; the whole pipe freezes while
//                     res_valid is high and res_ready is low
//   res_id            originating requester index
//   res_re/res_im     ((in1*wr - in2*wi) >>> SHIFT)[OW-1:0],
//                     ((in1*wi + in2*wr) >>> SHIFT)[OW-1:0]
//   busy              any pipeline stage holds valid data
module cmul_rr_arbiter import cmul_pkg::*; #(
    parameter int NREQ  = 4,
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = 0,
    parameter int IDW   = IDW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_in1,
    input  logic [NREQ*DW-1:0] req_in2,
    input  logic [NREQ*DW-1:0] req_wr,
    input  logic [NREQ*DW-1:0] req_wi,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [OW-1:0]      res_re,
    output logic [OW-1:0]      res_im,
    output logic               busy
);

    logic [PTRW-1:0]     last_r;
    logic [NREQ_MAX-1:0] valid_ext_s;
    logic [PTRW:0]       pick_s;
    logic                grant_found_s;
    logic [PTRW-1:0]     grant_idx_s;
    logic                stall_s;
    logic                accept_s;
    logic [DW-1:0]       sel_in1_s, sel_in2_s, sel_wr_s, sel_wi_s;

    // Round-robin search over the valids, padded to the package maximum.
    always_comb begin
        valid_ext_s            = {NREQ_MAX{1'b0}};
        valid_ext_s[NREQ-1:0]  = req_valid;
        pick_s                 = rr_next_grant(valid_ext_s, last_r, NREQ);
        grant_found_s          = pick_s[PTRW];
        grant_idx_s            = pick_s[PTRW-1:0];
    end

    // Nothing is accepted while the output is blocked or reset is held.
    assign stall_s  = res_valid & ~res_ready;
    assign accept_s = grant_found_s & ~stall_s & ~rst;

    // One-hot accept strobe and operand mux (AND-OR select on the grant).
    always_comb begin
        req_ready = {NREQ{1'b0}};
        sel_in1_s = {DW{1'b0}};
        sel_in2_s = {DW{1'b0}};
        sel_wr_s  = {DW{1'b0}};
        sel_wi_s  = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept_s & (grant_idx_s == PTRW'(i));
            sel_in1_s = sel_in1_s | (req_in1[i*DW +: DW] & {DW{grant_idx_s == PTRW'(i)}});
            sel_in2_s = sel_in2_s | (req_in2[i*DW +: DW] & {DW{grant_idx_s == PTRW'(i)}});
            sel_wr_s  = sel_wr_s  | (req_wr[i*DW +: DW]  & {DW{grant_idx_s == PTRW'(i)}});
            sel_wi_s  = sel_wi_s  | (req_wi[i*DW +: DW]  & {DW{grant_idx_s == PTRW'(i)}});
        end
    end

    // Round-robin pointer: moves to the granted index only on acceptance;
    // reset value NREQ-1 gives requester 0 top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= PTRW'(NREQ - 1);
        end else if (accept_s) begin
            last_r <= grant_idx_s;
        end
    end

    cmul_pipe #(
        .DW    (DW),
        .OW    (OW),
        .SHIFT (SHIFT),
        .IDW   (IDW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (~stall_s),
        .in_valid  (accept_s),
        .in_id     (IDW'(grant_idx_s)),
        .in1       (sel_in1_s),
        .in2       (sel_in2_s),
        .wr        (sel_wr_s),
        .wi        (sel_wi_s),
        .out_valid (res_valid),
        .out_id    (res_id),
        .out_re    (res_re),
        .out_im    (res_im),
        .busy      (busy)
    );

endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// Directed bench for cmul_rr_arbiter: a SHIFT=0 instance (main) and a
// SHIFT=15 instance driven by the same inputs. A negedge scoreboard checks
// every output transfer against a longint reference of each accepted set.
module tb_cmul_rr_arbiter;
    import cmul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_in1, req_in2, req_wr, req_wi;
    logic        res_valid, res_ready, busy;
    logic [1:0]  res_id;
    logic [16:0] res_re, res_im;

    logic [3:0]  s15_ready;
    logic        s15_valid, s15_busy;
    logic [1:0]  s15_id;
    logic [16:0] s15_re, s15_im;

    cmul_op_t ops [4];
    cmul_op_t stream_ops [5];

    typedef struct {
        logic [1:0]  id;
        logic [16:0] re;
        logic [16:0] im;
    } exp_t;
    exp_t sb [$];

    int n_checks = 0;
    int n_errors = 0;
    int pop_cnt  = 0;

    always #5 clk = ~clk;

    cmul_rr_arbiter #(.NREQ(4), .DW(16), .OW(17), .SHIFT(0), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_wr(req_wr), .req_wi(req_wi),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_re(res_re), .res_im(res_im), .busy(busy)
    );

    cmul_rr_arbiter #(.NREQ(4), .DW(16), .OW(17), .SHIFT(15), .IDW(2)) dut_s15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s15_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_wr(req_wr), .req_wi(req_wi),
        .res_valid(s15_valid), .res_ready(res_ready), .res_id(s15_id),
        .res_re(s15_re), .res_im(s15_im), .busy(s15_busy)
    );

    // Pack the per-requester operand records onto the flat buses.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_in1[i*16 +: 16] = ops[i].in1;
            req_in2[i*16 +: 16] = ops[i].in2;
            req_wr[i*16 +: 16]  = ops[i].wr;
            req_wi[i*16 +: 16]  = ops[i].wi;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input int i);
        exp_t   e;
        longint a, b, c, d, tr, ti;
        a  = ops[i].in1;
        b  = ops[i].in2;
        c  = ops[i].wr;
        d  = ops[i].wi;
        tr = a * c - b * d;
        ti = a * d + b * c;
        e.id = i[1:0];
        e.re = tr[16:0];
        e.im = ti[16:0];
        return e;
    endfunction

    // Scoreboard: pop on output transfer first, then push this edge's accept.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check("sb_spurious_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_id", 32'(res_id), 32'(e.id));
                    check("sb_re", 32'(res_re), 32'(e.re));
                    check("sb_im", 32'(res_im), 32'(e.im));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) sb.push_back(model(i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    initial begin
        int sent;
        int pre;
        rst       = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) ops[i] = '{16'd0, 16'd0, 16'd0, 16'd0};
        stream_ops[0] = '{16'd10,     16'd1,     16'd2,     16'd3};
        stream_ops[1] = '{16'hFFF6,   16'd7,     16'd5,     16'hFFFE};
        stream_ops[2] = '{16'd1000,   16'd2000,  16'd3000,  16'd4000};
        stream_ops[3] = '{16'h7FFF,   16'h7FFF,  16'h7FFF,  16'h7FFF};
        stream_ops[4] = '{16'h8000,   16'd1,     16'd1,     16'h8000};

        // Reset state, with every requester asking.
        tick();
        tick();
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_re", 32'(res_re), 32'd0);
        check("rst_res_im", 32'(res_im), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single request from requester 0: 3+4j times 2+1j = 2+11j.
        tick();
        rst       = 1'b0;
        req_valid = 4'b0001;
        ops[0]    = '{16'd3, 16'd4, 16'd2, 16'd1};
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        check("t1_lat1_valid", 32'(res_valid), 32'd0);
        check("t1_lat1_busy", 32'(busy), 32'd1);
        tick();
        #1;
        check("t1_lat2_valid", 32'(res_valid), 32'd0);
        tick();
        #1;
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_id", 32'(res_id), 32'd0);
        check("t1_re", 32'(res_re), 32'd2);
        check("t1_im", 32'(res_im), 32'd11);

        // Negative extremes on requester 2.
        tick();
        ops[2]    = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
        req_valid = 4'b0100;
        #1;
        check("t2_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        wait_result("t2_timeout");
        check("t2_id", 32'(res_id), 32'd2);
        check("t2_re", 32'(res_re), 32'h18000);
        check("t2_im", 32'(res_im), 32'h08000);

        // SHIFT=15 instance: 16384 * 32767 >>> 15 = 16383.
        tick();
        ops[0]    = '{16'd16384, 16'd0, 16'd32767, 16'd0};
        req_valid = 4'b0001;
        #1;
        check("t3_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        wait_result("t3_timeout");
        check("t3_s15_valid", 32'(s15_valid), 32'd1);
        check("t3_s15_id", 32'(s15_id), 32'd0);
        check("t3_s15_re", 32'(s15_re), 32'd16383);
        check("t3_s15_im", 32'(s15_im), 32'd0);

        // All four contending after reset: grants 0,1,2,3,0,1, results back to back.
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        ops[0] = '{16'd5,    16'd7,    16'hFFFD, 16'd2};
        ops[1] = '{16'hFF00, 16'd300,  16'd12,   16'hFFF0};
        ops[2] = '{16'd1234, 16'hFB2E, 16'h0101, 16'd99};
        ops[3] = '{16'd1,    16'd1,    16'd1,    16'd1};
        for (int c = 0; c < 10; c++) begin
            tick();
            req_valid = (c < 6) ? 4'hF : 4'h0;
            #1;
            if (c < 6) check("t4_grant", 32'(req_ready), 32'd1 << (c % 4));
            check("t4_res_valid", 32'(res_valid), (c >= 3 && c < 9) ? 32'd1 : 32'd0);
            if (c >= 3 && c < 9) check("t4_res_id", 32'(res_id), 32'((c - 3) % 4));
        end

        // Backpressure: five requests on requester 1, res_ready low for 3 cycles.
        pre  = pop_cnt;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            res_ready = !(c >= 3 && c <= 5);
            if (sent < 5) begin
                ops[1]    = stream_ops[sent];
                req_valid = 4'b0010;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (res_valid && !res_ready) check("t5_stall_ready", 32'(req_ready), 32'd0);
            if (req_ready[1]) sent++;
        end
        check("t5_sent", 32'(sent), 32'd5);
        check("t5_popped", 32'(pop_cnt - pre), 32'd5);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        check("t5_drained_busy", 32'(busy), 32'd0);

        // Reset with three results in flight, then req1/req3 contend.
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid = 4'hF;
        end
        tick();
        req_valid = 4'h0;
        rst       = 1'b1;
        #1;
        check("t6_inflight_busy", 32'(busy), 32'd1);
        tick();
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        wait_result("t6_timeout");
        check("t6_id", 32'(res_id), 32'd1);
        repeat (4) tick();
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
